mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage pipeline, placed between the EX/MEM and MEM/WB pipeline registers. Non-memory instructions pass through in zero cycles. Loads and stores drive a req/ack data bus and hold the pipeline through `stallreq` until the access completes. Load data is lane-selected and sign- or zero-extended before it goes to writeback.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width.

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_wd`  in  5  destination register from EX/MEM
- `mem_wreg`  in  1  write-enable from EX/MEM
- `mem_wdata`  in  32  EX result, used for non-memory ops
- `mem_aluop`  in  8  operation code from EX/MEM
- `mem_addr`  in  ADDR_W  effective address (byte address)
- `mem_reg2`  in  32  store data
- `stall`  in  6  pipeline stall vector; `stall[4]` holds this stage's result
- `flush`  in  1  pipeline flush
- `dbus_req`  out  1  bus request, registered
- `dbus_we`  out  1  1 = store
- `dbus_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- `dbus_sel`  out  4  byte-lane enables, big-endian
- `dbus_wdata`  out  32  store data, replicated to lanes
- `dbus_rdata`  in  32  read data, valid with ack
- `dbus_ack`  in  1  single-cycle completion strobe
- `wb_wd`  out  5  to MEM/WB
- `wb_wreg`  out  1  to MEM/WB
- `wb_wdata`  out  32  to MEM/WB
- `stallreq`  out  1  to pipeline control
- `excp_misalign`  out  1  misaligned-access flag, present only with `MEM_ALIGN_CHECK_EN`

## Operation
- FSM states: `IDLE`, `WAIT`, `DONE`.
- **IDLE, non-memory op:**
  - `wb_*` follow `mem_wd`, `mem_wreg` and `mem_wdata` combinationally.
  - `stallreq` = 0.
- **IDLE, memory op** (LB, LBU, LH, LHU, LW, SB, SH, SW):
  - `stallreq` = 1 combinationally.
  - `wb_wreg` = 0.
  - Next state is `WAIT`.
  - The bus registers are loaded at that edge: `dbus_req` = 1, plus addr, sel, we and wdata.
- **Lane mapping**, big-endian:
  - Byte access: `addr[1:0]` of 0, 1, 2, 3 gives `sel` 1000, 0100, 0010, 0001.
  - Halfword access: `addr[1]` of 0 or 1 gives `sel` 1100 or 0011.
  - Word access: `sel` = 1111.
  - Store data is the byte or halfword replicated across all lanes.
- **WAIT:**
  - Bus outputs are held stable and `stallreq` = 1.
  - On `dbus_ack`: `dbus_req` drops at the next edge, the extracted and extended load result is captured into the result register, and next state is `DONE`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Stores capture `wreg` = 0.
- **DONE:**
  - `wb_*` come from the result register and `stallreq` = 0.
  - If `stall[4]` is asserted the FSM stays in `DONE`; otherwise it returns to `IDLE`.
- **Flush:**
  - In `IDLE` or `DONE`: go to `IDLE`.
  - In `WAIT`: the transaction is never abandoned. The FSM waits for ack, discards the data, and goes to `IDLE`. A pending-flush bit records this, and `wb_wreg` stays 0.
- **Reset:**
  - All registers clear asynchronously and the state becomes `IDLE`.
  - `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_sel` and `dbus_wdata` = 0.
  - While `rst` = 0, `wb_wd` = 0, `wb_wreg` = 0, `wb_wdata` = 0, `stallreq` = 0 and `excp_misalign` = 0.
  - Reset asserted during `WAIT` abandons the bus transaction; the memory side is reset with it.

## Timing
- Non-memory ops: 0-cycle latency through this stage.
- Memory op with ack k cycles after the request (k ≥ 0):
  - Cycle 0: `IDLE`, op presented.
  - Cycles 1..1+k: `dbus_req` = 1.
  - Cycle 2+k: `DONE`; MEM/WB captures at the end of this cycle.
  - Minimum total is 3 cycles; `stallreq` is high for 2+k cycles.
- `dbus_ack` is ignored outside `WAIT`.
- An op arriving in the cycle after `DONE` is handled normally; back-to-back loads are allowed with no bubble beyond the above.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A halfword access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, issues no bus request.
  - `excp_misalign` = 1 for one cycle in `IDLE`, `wb_wreg` = 0, `stallreq` = 0.
- Undefined:
  - The `excp_misalign` port is absent.
  - Low address bits below the access size are ignored; halfword uses `addr[1]` only, and word is forced aligned.

## Structure
- Load/store aluop codes (`EXE_LB_OP` … `EXE_SW_OP`), FSM state encodings and `NOPRegAddr`/`ZeroWord` go in the shared defines file.
- Sub-module `mem_lane`: purely combinational. It produces the lane select and store replication, and performs load extraction and extension.

## Test plan
- `mem_aluop` = ADD, `mem_wdata` = 0x1234 -> same cycle `wb_wdata` = 0x1234, `stallreq` = 0.
- LB, `addr` = 0x101, memory word 0x00F0_0000, ack 0 cycles after the request -> `sel` = 0100, `wb_wdata` = 0xFFFF_FFF0 in cycle 2, `stallreq` high for 2 cycles.
- SH, `addr` = 0x202, `reg2` = 0xABCD, ack after 3 cycles -> `sel` = 0011, `wdata` = 0xABCD_ABCD, `we` = 1, `wb_wreg` = 0, `stallreq` high for 5 cycles.
- LW in `WAIT` with `flush` pulse, ack 2 cycles later -> `dbus_req` held until ack, FSM returns to `IDLE`, no register write.
- LHU in `DONE` with `stall[4]` = 1 for 2 cycles -> `wb_wdata` stable, FSM stays in `DONE`, returns to `IDLE` when `stall[4]` drops.
- `MEM_ALIGN_CHECK_EN`, LW at 0x3 -> no `dbus_req`, `excp_misalign` = 1. Without the macro, the same LW -> `addr` = 0x0 and the normal access completes.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared defines for the memory-access stage: aluop codes, FSM states, access sizes.
package mem_access_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic access_size_e op_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            default:                          return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// mem_lane: combinational big-endian lane select, store replication and load extraction.
// The misalign flag exists only when MEM_ALIGN_CHECK_EN is defined.
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [7:0]  req_op,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_data,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    input  logic [7:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte lane 0 sits in the most significant byte of the bus word.
    always_comb begin
        sel       = 4'b1111;
        wdata_rep = req_data;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = 1'b0;
`endif
        case (op_size(req_op))
            SZ_BYTE: begin
                sel       = 4'b1000 >> req_off;
                wdata_rep = {4{req_data[7:0]}};
            end
            SZ_HALF: begin
                sel       = req_off[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{req_data[15:0]}};
`ifdef MEM_ALIGN_CHECK_EN
                misaligned = req_off[0];
`endif
            end
            default: begin
                sel       = 4'b1111;
                wdata_rep = req_data;
`ifdef MEM_ALIGN_CHECK_EN
                misaligned = |req_off;
`endif
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_off)
            2'd0:    ld_byte = rdata[31:24];
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = ld_off[1] ? rdata[15:0] : rdata[31:16];

        ld_data = rdata;
        case (ld_op)
            EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ld_data = {24'h0, ld_byte};
            EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ld_data = {16'h0, ld_half};
            default:    ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes non-memory ops through, runs loads/stores over a req/ack bus.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access detection and the excp_misalign port.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_reg2,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [31:0]       dbus_wdata,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              stallreq
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              excp_misalign
`endif
);

    mem_state_e  state;
    logic [7:0]  op_r;
    logic [1:0]  off_r;
    logic [4:0]  res_wd;
    logic        res_wreg;
    logic [31:0] res_wdata;
    logic        pend_flush;

    logic        is_mem;
    logic        is_store;
    logic        start;
    logic        misaligned;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};
    assign is_mem       = is_mem_op(mem_aluop);
    assign is_store     = is_store_op(mem_aluop);

    mem_lane u_lane (
        .req_op     (mem_aluop),
        .req_off    (mem_addr[1:0]),
        .req_data   (mem_reg2),
        .sel        (lane_sel),
        .wdata_rep  (lane_wdata),
`ifdef MEM_ALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .ld_op      (op_r),
        .ld_off     (off_r),
        .rdata      (dbus_rdata),
        .ld_data    (ld_data)
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign misaligned = 1'b0;
`endif

    assign start = is_mem && !flush && !misaligned;

    // A flush seen in WAIT cannot abandon the bus cycle, so it is parked in pend_flush until ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= 4'b0000;
            dbus_wdata <= ZeroWord;
            op_r       <= EXE_NOP_OP;
            off_r      <= 2'b00;
            res_wd     <= NOPRegAddr;
            res_wreg   <= 1'b0;
            res_wdata  <= ZeroWord;
            pend_flush <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT;
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        dbus_sel   <= lane_sel;
                        dbus_wdata <= lane_wdata;
                        op_r       <= mem_aluop;
                        off_r      <= mem_addr[1:0];
                        res_wd     <= mem_wd;
                        res_wreg   <= mem_wreg && !is_store;
                        pend_flush <= 1'b0;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pend_flush <= 1'b1;
                    end
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        if (flush || pend_flush) begin
                            state      <= IDLE;
                            res_wreg   <= 1'b0;
                            pend_flush <= 1'b0;
                        end else begin
                            state     <= DONE;
                            res_wdata <= ld_data;
                        end
                    end
                end
                DONE: begin
                    if (flush || !stall[4]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writeback and stall request are combinational so non-memory ops cost zero cycles.
    always_comb begin
        wb_wd    = NOPRegAddr;
        wb_wreg  = 1'b0;
        wb_wdata = ZeroWord;
        stallreq = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        excp_misalign = 1'b0;
`endif
        if (rst) begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wb_wd    = mem_wd;
                        wb_wreg  = mem_wreg;
                        wb_wdata = mem_wdata;
                    end else begin
                        stallreq = start;
`ifdef MEM_ALIGN_CHECK_EN
                        excp_misalign = misaligned;
`endif
                    end
                end
                WAIT: stallreq = 1'b1;
                DONE: begin
                    wb_wd    = res_wd;
                    wb_wreg  = res_wreg;
                    wb_wdata = res_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus random loads/stores vs. an arithmetic model.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalign port.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [5:0]  stall;
    logic        flush;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
`ifdef MEM_ALIGN_CHECK_EN
    logic        excp_misalign;
`endif

    int total = 0;
    int bad   = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_aluop  (mem_aluop),
        .mem_addr   (mem_addr),
        .mem_reg2   (mem_reg2),
        .stall      (stall),
        .flush      (flush),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .stallreq   (stallreq)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .excp_misalign (excp_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 4;
    endfunction

    function automatic logic model_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Lanes covered: the naturally aligned block of op_bytes containing addr; lane 0 is sel[3].
    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        int n;
        int first;
        logic [3:0] s;
        n = op_bytes(op);
        first = (int'(addr % 4) / n) * n;
        s = 4'b0000;
        for (int lane = first; lane < first + n; lane++) s[3 - lane] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] data);
        int n;
        logic [31:0] unit;
        logic [31:0] v;
        n = op_bytes(op);
        unit = (n == 4) ? data : (data & ((32'd1 << (8 * n)) - 32'd1));
        v = 32'h0;
        for (int i = 0; i < 4 / n; i++) v = v | (unit << (8 * n * i));
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        int n;
        int first;
        logic [31:0] v;
        n = op_bytes(op);
        if (n == 4) return word;
        first = (int'(addr % 4) / n) * n;
        v = (word >> (8 * (4 - first - n))) & ((32'd1 << (8 * n)) - 32'd1);
        if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic apply_nonmem(input logic [31:0] data, input logic [4:0] wd);
        mem_aluop = EXE_ADD_OP;
        mem_wdata = data;
        mem_wd    = wd;
        mem_wreg  = 1'b1;
        #1;
        check_output("alu_wdata", wb_wdata, data);
        check_output("alu_wd", {27'h0, wb_wd}, {27'h0, wd});
        check_output("alu_wreg", {31'h0, wb_wreg}, 32'd1);
        check_output("alu_stallreq", {31'h0, stallreq}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge with the FSM idle; returns #1 after the edge that leaves DONE/WAIT.
    task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                  input logic [31:0] word, input int k, input int flush_at, input int hold);
        logic        store;
        logic [31:0] exp_ld;
        logic [4:0]  wd;
        int          scnt;
        logic        flushed;
        store   = model_store(op);
        exp_ld  = model_load(op, addr, word);
        wd      = 5'($urandom_range(1, 31));
        scnt    = 0;
        flushed = 1'b0;
        mem_aluop = op;
        mem_addr  = addr;
        mem_reg2  = reg2;
        mem_wd    = wd;
        mem_wreg  = 1'b1;
        mem_wdata = $urandom;
        flush     = 1'b0;
        stall     = 6'b0;
        dbus_ack  = 1'b0;
        @(negedge clk);
        check_output("c0_stallreq", {31'h0, stallreq}, 32'd1);
        check_output("c0_wreg", {31'h0, wb_wreg}, 32'd0);
        scnt += int'(stallreq);
        @(posedge clk);
        #1;
        check_output("bus_req", {31'h0, dbus_req}, 32'd1);
        check_output("bus_addr", dbus_addr, addr & ~32'd3);
        check_output("bus_sel", {28'h0, dbus_sel}, {28'h0, model_sel(op, addr)});
        check_output("bus_we", {31'h0, dbus_we}, {31'h0, store});
        if (store) check_output("bus_wdata", dbus_wdata, model_wdata(op, reg2));
        for (int c = 0; c <= k; c++) begin
            if (c == k) begin
                dbus_ack   = 1'b1;
                dbus_rdata = word;
            end else begin
                dbus_rdata = $urandom;
            end
            if (c == flush_at) begin
                flush     = 1'b1;
                flushed   = 1'b1;
                mem_aluop = EXE_NOP_OP;
                mem_wreg  = 1'b0;
                mem_wdata = 32'h5A5A_0000;
            end
            @(negedge clk);
            scnt += int'(stallreq);
            check_output("wait_req", {31'h0, dbus_req}, 32'd1);
            check_output("wait_addr", dbus_addr, addr & ~32'd3);
            check_output("wait_wreg", {31'h0, wb_wreg}, 32'd0);
            @(posedge clk);
            #1;
            dbus_ack = 1'b0;
            flush    = 1'b0;
        end
        @(negedge clk);
        check_output("stall_len", scnt, 2 + k);
        check_output("done_req", {31'h0, dbus_req}, 32'd0);
        check_output("done_stallreq", {31'h0, stallreq}, 32'd0);
        if (flushed) begin
            check_output("flush_wreg", {31'h0, wb_wreg}, 32'd0);
            check_output("flush_idle", wb_wdata, 32'h5A5A_0000);
        end else begin
            check_output("done_wreg", {31'h0, wb_wreg}, store ? 32'd0 : 32'd1);
            check_output("done_wd", {27'h0, wb_wd}, {27'h0, wd});
            if (!store) check_output("done_wdata", wb_wdata, exp_ld);
            if (hold > 0) begin
                stall = 6'b010000;
                for (int h = 1; h <= hold; h++) begin
                    @(posedge clk);
                    #1;
                    if (h == hold) stall = 6'b0;
                    @(negedge clk);
                    check_output("hold_stallreq", {31'h0, stallreq}, 32'd0);
                    check_output("hold_wreg", {31'h0, wb_wreg}, store ? 32'd0 : 32'd1);
                    if (!store) check_output("hold_wdata", wb_wdata, exp_ld);
                end
            end
        end
        @(posedge clk);
        #1;
        mem_aluop = EXE_NOP_OP;
        mem_wreg  = 1'b0;
    endtask

    logic [7:0] op_list [8];

    initial begin
        logic [7:0]  rop;
        logic [31:0] raddr;
        op_list = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                    EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        rst        = 1'b0;
        mem_wd     = 5'h1F;
        mem_wreg   = 1'b1;
        mem_wdata  = 32'hDEAD_BEEF;
        mem_aluop  = EXE_ADD_OP;
        mem_addr   = 32'h0;
        mem_reg2   = 32'h0;
        stall      = 6'b0;
        flush      = 1'b0;
        dbus_rdata = 32'h0;
        dbus_ack   = 1'b1;
        @(negedge clk);
        check_output("rst_wd", {27'h0, wb_wd}, 32'd0);
        check_output("rst_wreg", {31'h0, wb_wreg}, 32'd0);
        check_output("rst_wdata", wb_wdata, 32'd0);
        check_output("rst_stallreq", {31'h0, stallreq}, 32'd0);
        check_output("rst_req", {31'h0, dbus_req}, 32'd0);
        check_output("rst_sel", {28'h0, dbus_sel}, 32'd0);
        check_output("rst_addr", dbus_addr, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check_output("rst_excp", {31'h0, excp_misalign}, 32'd0);
`endif
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        rst      = 1'b1;

        apply_nonmem(32'h0000_1234, 5'd3);
        apply_stimulus(EXE_LB_OP, 32'h101, 32'h0, 32'h00F0_0000, 0, -1, 0);
        apply_stimulus(EXE_SH_OP, 32'h202, 32'h0000_ABCD, 32'h0, 3, -1, 0);
        apply_stimulus(EXE_LW_OP, 32'h300, 32'h0, 32'hCAFE_F00D, 2, 0, 0);
        apply_stimulus(EXE_LHU_OP, 32'h402, 32'h0, 32'h1234_8765, 1, -1, 2);
        apply_stimulus(EXE_LB_OP, 32'h103, 32'h0, 32'h0000_0080, 0, -1, 0);

`ifdef MEM_ALIGN_CHECK_EN
        mem_aluop = EXE_LW_OP;
        mem_addr  = 32'h3;
        mem_wreg  = 1'b1;
        #1;
        check_output("mis_excp", {31'h0, excp_misalign}, 32'd1);
        check_output("mis_stallreq", {31'h0, stallreq}, 32'd0);
        check_output("mis_wreg", {31'h0, wb_wreg}, 32'd0);
        @(posedge clk);
        #1;
        mem_aluop = EXE_NOP_OP;
        check_output("mis_noreq", {31'h0, dbus_req}, 32'd0);
        check_output("mis_excp_clear", {31'h0, excp_misalign}, 32'd0);
`else
        apply_stimulus(EXE_LW_OP, 32'h3, 32'h0, 32'h89AB_CDEF, 1, -1, 0);
`endif

        // Reset in the middle of a bus transaction abandons it.
        mem_aluop = EXE_LW_OP;
        mem_addr  = 32'h500;
        mem_wreg  = 1'b1;
        @(posedge clk);
        #1;
        check_output("rw_req", {31'h0, dbus_req}, 32'd1);
        rst = 1'b0;
        #1;
        check_output("rw_req_clr", {31'h0, dbus_req}, 32'd0);
        check_output("rw_stallreq", {31'h0, stallreq}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_nonmem(32'h0000_0077, 5'd9);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 8) == 8) begin
                apply_nonmem($urandom, 5'($urandom_range(0, 31)));
            end else begin
                rop   = op_list[$urandom_range(0, 7)];
                raddr = $urandom & 32'h0000_FFFF;
`ifdef MEM_ALIGN_CHECK_EN
                raddr = raddr & ~(32'(op_bytes(rop)) - 32'd1);
`endif
                apply_stimulus(rop, raddr, $urandom, $urandom, int'($urandom_range(0, 3)),
                               ($urandom_range(0, 5) == 0) ? 0 : -1, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
